// File: rtl/sha256d_nonce_sequencer.sv
// rtl/sha256d_nonce_sequencer.sv - double-SHA256 nonce sweep controller for one shared SHA256 core
// Block 1 is hashed once into a cached midstate; each nonce then runs block 2 (chained) and the second hash.
module sha256d_nonce_sequencer #(
    parameter int TIMEOUT = 1024,
    parameter int TMO_W   = 11
) (
    input  logic         CLK,
    input  logic         reset,
    input  logic         start,
    input  logic         abort,
    input  logic [639:0] header,
    input  logic [31:0]  nonce_start,
    input  logic [31:0]  nonce_end,
    input  logic [255:0] target,
    output logic         core_start,
    output logic [511:0] core_block,
    output logic         core_use_chain,
    output logic [255:0] core_chain,
    input  logic         core_done,
    input  logic [255:0] core_hash,
    output logic         busy,
    output logic         done,
    output logic         found,
    output logic [31:0]  found_nonce,
    output logic [255:0] found_hash,
    output logic         fault,
    output logic [32:0]  tried
);
    typedef enum logic [2:0] {
        S_IDLE, S_MID, S_B2, S_B3, S_CHECK, S_DONE
    } state_t;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT);

    state_t           state_q, state_d;
    logic [95:0]      tail_q, tail_d;
    logic [31:0]      nonce_q, nonce_d, nonce_end_q, nonce_end_d, nonce_inc;
    logic [255:0]     target_q, target_d, midstate_q, midstate_d, hash_q, hash_d;
    logic [TMO_W-1:0] wdog_q, wdog_d, wdog_inc;
    logic             core_start_q, core_start_d, use_chain_q, use_chain_d;
    logic [511:0]     block_q, block_d;
    logic             found_q, found_d, fault_q, fault_d;
    logic [31:0]      found_nonce_q, found_nonce_d;
    logic [255:0]     found_hash_q, found_hash_d;
    logic [32:0]      tried_q, tried_d;
    logic             unused_nonce_field;

    // The header nonce field is always replaced by the swept nonce.
    assign unused_nonce_field = ^header[31:0];
    assign wdog_inc           = wdog_q + TMO_W'(1);
    assign nonce_inc          = nonce_q + 32'd1;

    always_comb begin
        state_d       = state_q;
        tail_d        = tail_q;
        nonce_d       = nonce_q;
        nonce_end_d   = nonce_end_q;
        target_d      = target_q;
        midstate_d    = midstate_q;
        hash_d        = hash_q;
        wdog_d        = '0;
        core_start_d  = 1'b0;
        use_chain_d   = use_chain_q;
        block_d       = block_q;
        found_d       = found_q;
        fault_d       = fault_q;
        found_nonce_d = found_nonce_q;
        found_hash_d  = found_hash_q;
        tried_d       = tried_q;

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        tail_d        = header[127:32];
                        nonce_end_d   = nonce_end;
                        target_d      = target;
                        nonce_d       = nonce_start;
                        found_d       = 1'b0;
                        fault_d       = 1'b0;
                        tried_d       = '0;
                        found_nonce_d = '0;
                        found_hash_d  = '0;
                        block_d       = header[639:128];
                        use_chain_d   = 1'b0;
                        core_start_d  = 1'b1;
                        state_d       = S_MID;
                    end
                end
                S_MID, S_B2, S_B3: begin
                    if (core_done) begin
                        if (state_q == S_MID) begin
                            midstate_d   = core_hash;
                            block_d      = {tail_q, nonce_q, 1'b1, 319'b0, 64'd640};
                            use_chain_d  = 1'b1;
                            core_start_d = 1'b1;
                            state_d      = S_B2;
                        end else if (state_q == S_B2) begin
                            block_d      = {core_hash, 1'b1, 191'b0, 64'd256};
                            use_chain_d  = 1'b0;
                            core_start_d = 1'b1;
                            state_d      = S_B3;
                        end else begin
                            hash_d  = core_hash;
                            state_d = S_CHECK;
                        end
                    end else if (wdog_inc == TMO_LAST) begin
                        fault_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        wdog_d = wdog_inc;
                    end
                end
                S_CHECK: begin
                    tried_d = tried_q + 33'd1;
                    if (hash_q <= target_q) begin
                        found_d       = 1'b1;
                        found_nonce_d = nonce_q;
                        found_hash_d  = hash_q;
                        state_d       = S_DONE;
                    end else if (nonce_q == nonce_end_q) begin
                        state_d = S_DONE;
                    end else begin
                        // Next nonce reuses the cached midstate; block 1 is not rehashed.
                        nonce_d      = nonce_inc;
                        block_d      = {tail_q, nonce_inc, 1'b1, 319'b0, 64'd640};
                        use_chain_d  = 1'b1;
                        core_start_d = 1'b1;
                        state_d      = S_B2;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            tail_q        <= '0;
            nonce_q       <= '0;
            nonce_end_q   <= '0;
            target_q      <= '0;
            midstate_q    <= '0;
            hash_q        <= '0;
            wdog_q        <= '0;
            core_start_q  <= 1'b0;
            use_chain_q   <= 1'b0;
            block_q       <= '0;
            found_q       <= 1'b0;
            fault_q       <= 1'b0;
            found_nonce_q <= '0;
            found_hash_q  <= '0;
            tried_q       <= '0;
        end else begin
            state_q       <= state_d;
            tail_q        <= tail_d;
            nonce_q       <= nonce_d;
            nonce_end_q   <= nonce_end_d;
            target_q      <= target_d;
            midstate_q    <= midstate_d;
            hash_q        <= hash_d;
            wdog_q        <= wdog_d;
            core_start_q  <= core_start_d;
            use_chain_q   <= use_chain_d;
            block_q       <= block_d;
            found_q       <= found_d;
            fault_q       <= fault_d;
            found_nonce_q <= found_nonce_d;
            found_hash_q  <= found_hash_d;
            tried_q       <= tried_d;
        end
    end

    assign core_start     = core_start_q;
    assign core_block     = block_q;
    assign core_use_chain = use_chain_q;
    assign core_chain     = midstate_q;
    assign busy           = (state_q != S_IDLE);
    assign done           = (state_q == S_DONE);
    assign found          = found_q;
    assign found_nonce    = found_nonce_q;
    assign found_hash     = found_hash_q;
    assign fault          = fault_q;
    assign tried          = tried_q;
endmodule

// File: tb/tb_sha256d_nonce_sequencer.sv
// tb/tb_sha256d_nonce_sequencer.sv - bench for sha256d_nonce_sequencer with a 65-cycle SHA256 core model
module tb_sha256d_nonce_sequencer;
    localparam int TIMEOUT = 1024;
    localparam int TMO_W   = 11;
    localparam int LAT     = 65;
    localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         CLK = 1'b0;
    logic         reset, start, abort;
    logic [639:0] header;
    logic [31:0]  nonce_start, nonce_end;
    logic [255:0] target;
    logic         core_start, core_use_chain;
    logic [511:0] core_block;
    logic [255:0] core_chain;
    wire          core_done;
    wire  [255:0] core_hash;
    logic         busy, done, found, fault;
    logic [31:0]  found_nonce;
    logic [255:0] found_hash;
    logic [32:0]  tried;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int start_cnt = 0;
    int done_cnt = 0;
    int overlap_cnt = 0;
    int last_start_cyc = 0;
    logic [31:0]  b2_nonces[$];
    logic         m_busy = 1'b0, m_done = 1'b0, m_hang = 1'b0, inj_done = 1'b0;
    int           m_cnt = 0;
    logic [255:0] m_res = '0, inj_hash = '0;

    sha256d_nonce_sequencer #(.TIMEOUT(TIMEOUT), .TMO_W(TMO_W)) dut (
        .CLK(CLK), .reset(reset), .start(start), .abort(abort), .header(header),
        .nonce_start(nonce_start), .nonce_end(nonce_end), .target(target),
        .core_start(core_start), .core_block(core_block), .core_use_chain(core_use_chain),
        .core_chain(core_chain), .core_done(core_done), .core_hash(core_hash),
        .busy(busy), .done(done), .found(found), .found_nonce(found_nonce),
        .found_hash(found_hash), .fault(fault), .tried(tried)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [0:63];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0   = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
            s1   = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, h} = hin;
        for (int i = 0; i < 64; i++) begin
            t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {a + hin[255:224], b + hin[223:192], c + hin[191:160], d + hin[159:128],
                e + hin[127:96],  f + hin[95:64],   g + hin[63:32],   h + hin[31:0]};
    endfunction

    // Plain SHA256 of a byte string, with standard padding.
    function automatic logic [255:0] sha256_msg(input logic [7:0] msg[$]);
        logic [7:0]   m[$];
        logic [63:0]  bitlen;
        logic [255:0] hv;
        logic [511:0] blk;
        m      = msg;
        bitlen = 64'(msg.size()) * 64'd8;
        m.push_back(8'h80);
        while ((m.size() % 64) != 56) m.push_back(8'h00);
        for (int i = 7; i >= 0; i--) m.push_back(bitlen[8*i +: 8]);
        hv = IV;
        for (int ch = 0; ch < m.size() / 64; ch++) begin
            for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = m[64*ch + j];
            hv = sha_compress(hv, blk);
        end
        return hv;
    endfunction

    function automatic logic [255:0] ref_dsha(input logic [639:0] hdr, input logic [31:0] n);
        logic [7:0]   q[$];
        logic [255:0] h1;
        for (int i = 0; i < 76; i++) q.push_back(hdr[639-8*i -: 8]);
        for (int i = 3; i >= 0; i--) q.push_back(n[8*i +: 8]);
        h1 = sha256_msg(q);
        q.delete();
        for (int i = 0; i < 32; i++) q.push_back(h1[255-8*i -: 8]);
        return sha256_msg(q);
    endfunction

    function automatic logic [639:0] rand_hdr();
        logic [639:0] h;
        for (int i = 0; i < 20; i++) h[32*i +: 32] = $urandom();
        return h;
    endfunction

    // Behavioural core: result appears LAT cycles after the core_start cycle.
    always @(negedge CLK) begin
        m_done = 1'b0;
        if (reset) begin
            m_busy = 1'b0;
        end else begin
            if (m_busy) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    m_done = 1'b1;
                    m_busy = 1'b0;
                end
            end
            if (core_start) begin
                start_cnt      = start_cnt + 1;
                last_start_cyc = cyc;
                if (core_use_chain) b2_nonces.push_back(core_block[415:384]);
                if (m_busy) overlap_cnt = overlap_cnt + 1;
                if (!m_hang) begin
                    m_busy = 1'b1;
                    m_cnt  = LAT;
                    m_res  = sha_compress(core_use_chain ? core_chain : IV, core_block);
                end
            end
        end
        if (done) done_cnt = done_cnt + 1;
    end

    assign core_done = m_done | inj_done;
    assign core_hash = m_done ? m_res : inj_hash;

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_sweep(input string tag, input logic [639:0] hdr, input logic [31:0] ns,
                             input logic [31:0] ne, input logic [255:0] tgt);
        logic [31:0]  n;
        logic [255:0] d;
        logic         exp_found;
        logic [31:0]  exp_nonce;
        logic [255:0] exp_hash;
        int           exp_tried, base, s, dcyc;
        logic         seen;
        logic [31:0]  exp_n[$];
        n = ns; exp_found = 1'b0; exp_nonce = '0; exp_hash = '0; exp_tried = 0;
        for (int k = 0; k < 64; k++) begin
            d = ref_dsha(hdr, n);
            exp_tried++;
            exp_n.push_back(n);
            if (d <= tgt) begin
                exp_found = 1'b1; exp_nonce = n; exp_hash = d;
                break;
            end
            if (n == ne) break;
            n = n + 32'd1;
        end
        header = hdr; nonce_start = ns; nonce_end = ne; target = tgt;
        base = start_cnt;
        b2_nonces.delete();
        s = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        header = rand_hdr(); nonce_end = $urandom(); target = {8'h00, {248{1'b1}}} >> $urandom_range(0, 200);
        seen = 1'b0; dcyc = 0;
        for (int k = 0; k < 4000; k++) begin
            if (done) begin
                seen = 1'b1; dcyc = cyc;
                break;
            end
            tick();
        end
        chk({tag, ".done_seen"}, 256'(seen), 256'(1));
        if (seen) begin
            chk({tag, ".found"}, 256'(found), 256'(exp_found));
            chk({tag, ".found_nonce"}, 256'(found_nonce), 256'(exp_nonce));
            chk({tag, ".found_hash"}, found_hash, exp_hash);
            chk({tag, ".tried"}, 256'(tried), 256'(exp_tried));
            chk({tag, ".fault"}, 256'(fault), 256'(0));
            chk({tag, ".core_starts"}, 256'(start_cnt - base), 256'(1 + 2 * exp_tried));
            chk({tag, ".latency"}, 256'(dcyc - s), 256'(2 + LAT + exp_tried * (2 * LAT + 3)));
            chk({tag, ".nonce_count"}, 256'(b2_nonces.size()), 256'(exp_n.size()));
            for (int i = 0; i < exp_n.size() && i < b2_nonces.size(); i++)
                chk($sformatf("%s.nonce%0d", tag, i), 256'(b2_nonces[i]), 256'(exp_n[i]));
            tick();
            chk({tag, ".busy_after"}, 256'(busy), 256'(0));
            chk({tag, ".done_pulse"}, 256'(done), 256'(0));
        end
    endtask

    initial begin
        logic [639:0] h;
        logic [31:0]  ns, ne;
        logic [255:0] tgt;
        int           base, dbase, dcyc;
        logic         seen;

        reset = 1'b1; start = 1'b0; abort = 1'b0;
        header = '0; nonce_start = '0; nonce_end = '0; target = '0;
        repeat (3) tick();
        chk("rst.busy", 256'(busy), 256'(0));
        chk("rst.done", 256'(done), 256'(0));
        chk("rst.found", 256'(found), 256'(0));
        chk("rst.fault", 256'(fault), 256'(0));
        chk("rst.tried", 256'(tried), 256'(0));
        chk("rst.core_start", 256'(core_start), 256'(0));
        chk("rst.core_block_hi", core_block[511:256], 256'(0));
        chk("rst.core_block_lo", core_block[255:0], 256'(0));
        chk("rst.core_chain", core_chain, 256'(0));
        chk("rst.found_hash", found_hash, 256'(0));
        reset = 1'b0;
        tick();

        // start and abort together in IDLE: abort wins
        header = rand_hdr(); nonce_start = 32'd1; nonce_end = 32'd2; target = '1;
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        tick();
        chk("start_abort.busy", 256'(busy), 256'(0));
        chk("start_abort.core_starts", 256'(start_cnt), 256'(0));

        run_sweep("first_hit", rand_hdr(), 32'h10, 32'h20, '1);
        run_sweep("no_hit", rand_hdr(), 32'd5, 32'd7, '0);
        run_sweep("wrap", rand_hdr(), 32'hFFFFFFFE, 32'h00000001, '0);
        for (int i = 0; i < 4; i++) begin
            ns  = ($urandom_range(0, 1) == 1) ? 32'hFFFFFFFF - 32'($urandom_range(0, 2)) : 32'($urandom());
            ne  = ns + 32'($urandom_range(0, 3));
            tgt = {8'($urandom_range(0, 255)), {248{1'b1}}};
            run_sweep($sformatf("rand%0d", i), rand_hdr(), ns, ne, tgt);
        end

        // Core never answers: watchdog fault
        m_hang = 1'b1;
        header = rand_hdr(); nonce_start = 32'd0; nonce_end = 32'd9; target = '1;
        base = start_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        seen = 1'b0; dcyc = 0;
        for (int k = 0; k < 1500; k++) begin
            if (done) begin
                seen = 1'b1; dcyc = cyc;
                break;
            end
            tick();
        end
        chk("hang.done_seen", 256'(seen), 256'(1));
        chk("hang.fault", 256'(fault), 256'(1));
        chk("hang.found", 256'(found), 256'(0));
        chk("hang.latency", 256'(dcyc - last_start_cyc), 256'(TIMEOUT));
        chk("hang.core_starts", 256'(start_cnt - base), 256'(1));
        tick();
        chk("hang.busy_after", 256'(busy), 256'(0));
        m_hang = 1'b0;

        // Abort in B3 of the second nonce, coinciding with core_done
        header = rand_hdr(); nonce_start = 32'd100; nonce_end = 32'd110; target = '0;
        base = start_cnt; dbase = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if (start_cnt >= base + 5) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk("abort.reached_b3", 256'(seen), 256'(1));
        repeat (LAT) tick();
        abort = 1'b1;
        chk("abort.core_done_same_cycle", 256'(core_done), 256'(1));
        tick();
        abort = 1'b0;
        chk("abort.busy", 256'(busy), 256'(0));
        chk("abort.tried", 256'(tried), 256'(1));
        chk("abort.found", 256'(found), 256'(0));
        chk("abort.fault", 256'(fault), 256'(0));
        chk("abort.no_done", 256'(done_cnt - dbase), 256'(0));
        inj_hash = '0; inj_done = 1'b1;
        tick();
        inj_done = 1'b0;
        repeat (3) tick();
        chk("late_done.busy", 256'(busy), 256'(0));
        chk("late_done.no_done", 256'(done_cnt - dbase), 256'(0));
        chk("late_done.tried", 256'(tried), 256'(1));
        chk("late_done.core_starts", 256'(start_cnt - base), 256'(5));
        ns = $urandom();
        run_sweep("restart", rand_hdr(), ns, ns + 32'd2, '1);

        // Reset during B2
        header = rand_hdr(); nonce_start = 32'd0; nonce_end = 32'd50; target = '0;
        base = start_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 500 && start_cnt < base + 2; k++) tick();
        repeat (10) tick();
        chk("mid_rst.in_b2", 256'(core_use_chain), 256'(1));
        reset = 1'b1;
        #1;
        chk("mid_rst.busy", 256'(busy), 256'(0));
        chk("mid_rst.core_use_chain", 256'(core_use_chain), 256'(0));
        chk("mid_rst.core_chain", core_chain, 256'(0));
        chk("mid_rst.core_block_hi", core_block[511:256], 256'(0));
        chk("mid_rst.core_block_lo", core_block[255:0], 256'(0));
        chk("mid_rst.found_tried", 256'({found, fault, done, core_start, tried}), 256'(0));
        chk("mid_rst.found_nonce_hash", found_hash | 256'(found_nonce), 256'(0));
        repeat (2) tick();
        reset = 1'b0;
        base = start_cnt;
        repeat (300) tick();
        chk("mid_rst.no_starts", 256'(start_cnt - base), 256'(0));
        chk("mid_rst.idle", 256'(busy), 256'(0));

        chk("core_overlap", 256'(overlap_cnt), 256'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout cycles=%0d", cyc);
        $fatal(1, "bench timeout");
    end
endmodule

// File: doc/sha256d_nonce_sequencer.md
Name: sha256d_nonce_sequencer

Overview:
Controller that drives one shared SHA256 core to compute Bitcoin double-SHA256 over an 80-byte block header while sweeping the 32-bit nonce. It hashes header block 1 once and caches the midstate. For each nonce it then runs header block 2, chained from the midstate, and the second hash from the IV. It compares each final digest against a target and reports the first hit. It sits between the host/config registers and the SHA256 core.

Parameters:
TIMEOUT, 1024, max cycles from core_start to core_done before a core fault is declared
TMO_W, 11, width of watchdog counter (must hold TIMEOUT)

Ports:
CLK  in  1  clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; accepted only in IDLE, ignored otherwise
abort  in  1  level; returns to IDLE the next cycle from any state
header  in  640  header bits; [639:128] = block 1, [127:32] = tail, [31:0] = nonce field (ignored, replaced)
nonce_start  in  32  first nonce
nonce_end  in  32  last nonce, inclusive
target  in  256  hit if final digest <= target, unsigned, no byte reversal
core_start  out  1  one-cycle pulse; launches the core
core_block  out  512  message block; held stable from core_start until core_done
core_use_chain  out  1  1 = core starts from core_chain; 0 = from SHA256 IV
core_chain  out  256  chaining value (cached midstate)
core_done  in  1  one-cycle pulse; core_hash valid in the same cycle
core_hash  in  256  core result
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at end of sweep, hit or fault
found  out  1  valid with done; held until next accepted start
found_nonce  out  32  nonce of the hit
found_hash  out  256  final digest of the hit
fault  out  1  core watchdog expired; held until next accepted start
tried  out  33  count of nonces fully evaluated

Behaviour:
- Reset: state=IDLE; all outputs 0, including core_block, core_chain and the tried counter.
- start in IDLE: latch header, nonce_end and target; nonce<=nonce_start; clear found/fault/tried and the found_* outputs; go MID.
- MID: pulse core_start with core_block=header[639:128] and core_use_chain=0. On core_done, midstate<=core_hash; go B2.
- B2: pulse core_start with core_block={header[127:32], nonce, 1'b1, 319'b0, 64'd640} and core_use_chain=1, core_chain=midstate. On core_done, h1<=core_hash; go B3.
- B3: pulse core_start with core_block={h1, 1'b1, 191'b0, 64'd256} and core_use_chain=0. On core_done go CHECK.
- CHECK (one cycle): tried<=tried+1.
  - If digest<=target: found=1, found_nonce=nonce, found_hash=digest; go DONE.
  - Else if nonce==nonce_end: go DONE.
  - Else nonce<=nonce+1 mod 2^32; go B2. The midstate is not recomputed.
- DONE: done=1 for one cycle; go IDLE.
- core_start fires exactly one cycle after entering MID, B2 or B3. The FSM never issues a second core_start before core_done.
- Wrap: nonce_end < nonce_start sweeps through 0xFFFFFFFF to 0. start==end evaluates exactly one nonce. The full range 0..0xFFFFFFFF gives tried=2^32 (33-bit counter, no overflow).
- Watchdog: counts cycles in MID/B2/B3 after core_start; cleared on core_done. On reaching TIMEOUT: fault=1, go DONE (done pulses, found=0).
- abort: go IDLE next cycle, no done pulse. found/fault/tried keep their last values.
- core_done received in IDLE or DONE is ignored.
- abort and core_done in the same cycle: abort wins; the result is discarded.
- start and abort in the same cycle in IDLE: abort wins; start is not accepted.
- Latency per nonce equals 2 core latencies plus 3 cycles (launch B2, launch B3, CHECK). One extra core latency plus 1 cycle is spent once for the midstate.

Test Plan:
- Bench uses a behavioural SHA256 core with 65-cycle latency.
- target=all ones, nonce_start=0x10, end=0x20 -> done after the first nonce; found=1, found_nonce=0x10, tried=1; 3 core_start pulses; found_hash matches a software double-SHA256 of the header with nonce 0x10.
- target=0, nonce_start=5, end=7 -> 7 core_start pulses (1 midstate + 2x3); done with found=0, tried=3; core_block nonce fields are 5, 6, 7 in order.
- target=0, nonce_start=0xFFFFFFFE, end=0x00000001 -> nonces FFFFFFFE, FFFFFFFF, 0, 1 evaluated; tried=4; done with found=0.
- Core model never returns core_done -> fault=1 and done pulse exactly TIMEOUT cycles after the first core_start; busy=0 the next cycle.
- abort asserted during B3 of the second nonce, with a core_done pulse in the same cycle -> IDLE next cycle, no done pulse, tried=1. A late core_done is ignored. A new start then completes normally.
- Assert reset mid-sweep (during B2) -> all outputs 0 immediately; busy=0; no further core_start pulses until a new start.
